// File: rtl/muladdsub_pkg.sv
// muladdsub_pkg: shared widths, FSM states, vector layout, corner table, LFSR slicing and bit-exact A*B +/- C + CIN reference
package muladdsub_pkg;
    localparam int A_W = 18;
    localparam int C_W = 54;
    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;
    typedef struct packed {
        logic [A_W-1:0] a;
        logic [A_W-1:0] b;
        logic [C_W-1:0] c;
        logic           sgn;
        logic           addsub;
        logic           cin;
    } vec_t;
    localparam vec_t CORNERS [4] = '{
        '{18'h00000, 18'h00000, 54'h0,                1'b0, 1'b0, 1'b0},
        '{18'h3FFFF, 18'h3FFFF, 54'h0,                1'b0, 1'b0, 1'b1},
        '{18'h20000, 18'h20000, 54'h0,                1'b1, 1'b0, 1'b0},
        '{18'h20000, 18'h1FFFF, 54'h3F_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b1}
    };
    function automatic vec_t vec_from_rnd(input logic [127:0] r);
        return '{a: r[17:0], b: r[35:18], c: r[117:64], sgn: r[36], addsub: r[37], cin: r[38]};
    endfunction
    // Extending both operands to C_W bits first makes the truncated product equal sext54/zext54 of the 36-bit product.
    function automatic logic [C_W-1:0] muladdsub_expect(
        input logic [A_W-1:0] a,
        input logic [A_W-1:0] b,
        input logic [C_W-1:0] c,
        input logic           sgn,
        input logic           addsub,
        input logic           cin
    );
        logic [C_W-1:0] ax, bx, p;
        ax = sgn ? {{(C_W-A_W){a[A_W-1]}}, a} : {{(C_W-A_W){1'b0}}, a};
        bx = sgn ? {{(C_W-A_W){b[A_W-1]}}, b} : {{(C_W-A_W){1'b0}}, b};
        p = ax * bx;
        return (addsub ? c - p : c + p) + {{(C_W-1){1'b0}}, cin};
    endfunction
endpackage

// File: rtl/muladdsub_lfsr.sv
// muladdsub_lfsr: 64-bit Galois LFSR (x^64+x^63+x^61+x^60+1); ports clk, rst, load (reload SEED), step (advance two steps), rnd = {step2, step1}
module muladdsub_lfsr #(
    parameter logic [63:0] SEED = 64'hACE1_F00D
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    output logic [127:0] rnd
);
    logic [63:0] state, s1, s2;
    function automatic logic [63:0] nxt(input logic [63:0] s);
        return (s >> 1) ^ (s[0] ? 64'hD800_0000_0000_0000 : 64'h0);
    endfunction
    assign s1 = nxt(state);
    assign s2 = nxt(s1);
    assign rnd = {s2, s1};
    always_ff @(posedge clk) begin
        if (rst || load) state <= SEED;
        else if (step) state <= s2;
    end
endmodule

// File: rtl/muladdsub_stim_checker.sv
// muladdsub_stim_checker: drives corner + LFSR vectors into a combinational MULTADDSUB18X18 (dut_*), checks dut_z, reports busy/done/pass/vec_count/err_count/fail_idx/fail_z/fail_exp
module muladdsub_stim_checker
    import muladdsub_pkg::*;
#(
    parameter int          NUM_VECTORS   = 1024,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [63:0] SEED          = 64'hACE1_F00D
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic [A_W-1:0] dut_a,
    output logic [A_W-1:0] dut_b,
    output logic [C_W-1:0] dut_c,
    output logic           dut_signed,
    output logic           dut_addsub,
    output logic           dut_cin,
    input  logic [C_W-1:0] dut_z,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [15:0]    vec_count,
    output logic [15:0]    err_count,
    output logic [15:0]    fail_idx,
    output logic [C_W-1:0] fail_z,
    output logic [C_W-1:0] fail_exp
);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] NUM_LAST    = 16'(NUM_VECTORS - 1);
    state_t         state;
    logic [C_W-1:0] exp_z;
    logic [15:0]    settle_cnt;
    logic [127:0]   rnd;
    vec_t           vec;
    logic           lfsr_load, lfsr_step, mismatch;
    assign lfsr_load = start && (state == IDLE || state == DONE);
    assign lfsr_step = state == DRIVE;
    assign mismatch  = dut_z != exp_z;
    // vec_count doubles as the vector index: it advances exactly once per CHECK.
    assign vec = vec_count < 16'd4 ? CORNERS[vec_count[1:0]] : vec_from_rnd(rnd);
    muladdsub_lfsr #(.SEED(SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .step (lfsr_step),
        .rnd  (rnd)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dut_a      <= '0;
            dut_b      <= '0;
            dut_c      <= '0;
            dut_signed <= 1'b0;
            dut_addsub <= 1'b0;
            dut_cin    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            vec_count  <= '0;
            err_count  <= '0;
            fail_idx   <= '0;
            fail_z     <= '0;
            fail_exp   <= '0;
            exp_z      <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state     <= DRIVE;
                    busy      <= 1'b1;
                    done      <= 1'b0;
                    pass      <= 1'b0;
                    vec_count <= '0;
                    err_count <= '0;
                    fail_idx  <= '0;
                    fail_z    <= '0;
                    fail_exp  <= '0;
                end
                DRIVE: begin
                    dut_a      <= vec.a;
                    dut_b      <= vec.b;
                    dut_c      <= vec.c;
                    dut_signed <= vec.sgn;
                    dut_addsub <= vec.addsub;
                    dut_cin    <= vec.cin;
                    exp_z      <= muladdsub_expect(vec.a, vec.b, vec.c, vec.sgn, vec.addsub, vec.cin);
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 16'd1;
                    if (settle_cnt == SETTLE_LAST) state <= CHECK;
                end
                CHECK: begin
                    vec_count <= vec_count + 16'd1;
                    if (mismatch) begin
                        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                        if (err_count == 16'd0) begin
                            fail_idx <= vec_count;
                            fail_z   <= dut_z;
                            fail_exp <= exp_z;
                        end
                    end
                    if (vec_count == NUM_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !mismatch && err_count == 16'd0;
                    end else begin
                        state <= DRIVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
